// File: rtl/ifu_axi_fetch.sv
// ifu_axi_fetch: instruction-fetch AXI4-Lite read master.
//
// Accepts fetch requests from the PC stage, issues them on the AR channel,
// and returns instructions in order through a DEPTH-entry response FIFO.
// A slot is reserved on request accept, so the FIFO can never overflow and
// rready stays high in normal operation. A flush pulse empties the FIFO and
// marks every outstanding read as wrong-path; those R beats are dropped on
// arrival. The write channels are tied idle.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  fetch request handshake (IFU side)
//   flush                         one-cycle pulse, drop all pending fetches
//   resp_valid/resp_ready         response handshake (decode side)
//   resp_data/resp_err            head-of-queue instruction and error flag
//   aw*/w*/b*                     write channels, constant 0 / ignored
//   araddr/arvalid/arready        AXI read address channel
//   rdata/rresp/rvalid/rready     AXI read data channel

// Protocol checker bound into the fetch master.
module ifu_axi_fetch_chk #(
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          awvalid,
  input  logic          wvalid,
  input  logic          bready,
  input  logic          rvalid,
  input  logic          rready,
  input  logic          push,
  input  logic          pop,
  input  logic [CW-1:0] inflight,
  input  logic [CW-1:0] fifo_cnt
);
  a_write_idle: assert property (@(posedge clk) disable iff (!rst)
    !awvalid && !wvalid && !bready);

  a_no_stray_r: assert property (@(posedge clk) disable iff (!rst)
    !(rvalid && rready && (inflight == {CW{1'b0}})));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (fifo_cnt == CW'(DEPTH))));
endmodule

module ifu_axi_fetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                flush,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic              arvalid_r;
  logic [ADDR_W-1:0] araddr_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     inflight_r;
  logic [CW-1:0]     discard_r;
  logic [CW-1:0]     fifo_cnt_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [DATA_W:0]   mem_r [DEPTH];

  logic          req_fire_s;
  logic          ar_fire_s;
  logic          r_fire_s;
  logic          drop_s;
  logic          push_s;
  logic          pop_s;
  logic [CW-1:0] flush_cnt_s;
  logic          unused_s;

  // Pointer increment with explicit wrap so non-trivial DEPTH=1 stays at 0.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  assign req_ready  = !flush && (!arvalid_r || arready) && (cnt_r < DEPTH_C);
  assign resp_valid = (fifo_cnt_r != ZERO_C) && !flush;
  assign resp_data  = mem_r[rd_ptr_r][DATA_W:1];
  assign resp_err   = mem_r[rd_ptr_r][0];
  assign rready     = (fifo_cnt_r < DEPTH_C);
  assign arvalid    = arvalid_r;
  assign araddr     = araddr_r;

  assign awaddr  = {ADDR_W{1'b0}};
  assign awvalid = 1'b0;
  assign wdata   = {DATA_W{1'b0}};
  assign wstrb   = {(DATA_W/8){1'b0}};
  assign wvalid  = 1'b0;
  assign bready  = 1'b0;
  assign unused_s = ^{awready, wready, bresp, bvalid, req_addr[1:0]};

  assign req_fire_s = req_valid && req_ready;
  assign ar_fire_s  = arvalid_r && arready;
  assign r_fire_s   = rvalid && rready;
  assign pop_s      = resp_valid && resp_ready;
  // Wrong-path beats are dropped; a beat landing in the flush cycle itself is
  // also wrong-path, so it is never pushed.
  assign drop_s     = r_fire_s && (discard_r != ZERO_C);
  assign push_s     = r_fire_s && (discard_r == ZERO_C) && !flush;
  // Every read still owed by the slave after this cycle is wrong-path. Reads
  // already being discarded are part of inflight_r, so flushes accumulate.
  assign flush_cnt_s = inflight_r + CW'(arvalid_r) - CW'(r_fire_s);

  // AR channel: load on accept, hold until handshake, back-to-back reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arvalid_r <= 1'b0;
      araddr_r  <= {ADDR_W{1'b0}};
    end else if (req_fire_s) begin
      arvalid_r <= 1'b1;
      araddr_r  <= {req_addr[ADDR_W-1:2], 2'b00};
    end else if (ar_fire_s) begin
      arvalid_r <= 1'b0;
    end else begin
      arvalid_r <= arvalid_r;
    end
  end

  // Slot reservation, in-flight and discard bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= ZERO_C;
      discard_r  <= ZERO_C;
      inflight_r <= ZERO_C;
    end else begin
      if (flush) begin
        cnt_r     <= flush_cnt_s;
        discard_r <= flush_cnt_s;
      end else begin
        cnt_r     <= cnt_r + CW'(req_fire_s) - CW'(pop_s) - CW'(drop_s);
        discard_r <= discard_r - CW'(drop_s);
      end
      inflight_r <= inflight_r + CW'(ar_fire_s) - CW'(r_fire_s);
    end
  end

  // Response FIFO storing {rdata, error}; flush empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= ZERO_C;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(DATA_W + 1){1'b0}};
      end
    end else if (flush) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      fifo_cnt_r <= ZERO_C;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {rdata, (rresp != 2'b00)};
        wr_ptr_r        <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      fifo_cnt_r <= fifo_cnt_r + CW'(push_s) - CW'(pop_s);
    end
  end

  ifu_axi_fetch_chk #(.DEPTH(DEPTH), .CW(CW)) u_chk (
    .clk      (clk),
    .rst      (rst),
    .awvalid  (awvalid),
    .wvalid   (wvalid),
    .bready   (bready),
    .rvalid   (rvalid),
    .rready   (rready),
    .push     (push_s),
    .pop      (pop_s),
    .inflight (inflight_r),
    .fifo_cnt (fifo_cnt_r)
  );
endmodule
